vram_arbiter: RTL and testbench



---
 rtl/vram_arbiter.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_vram_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// Arbitrates the SDRAM controller between renderer, CPU and command engine and
// inserts periodic auto-refresh. One operation is outstanding at a time.
module vram_arbiter #(
  parameter int FREQ             = 54_000_000,
  parameter int REFRESH_INTERVAL = 810
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        render_req,
  input  logic [22:0] render_addr,
  output logic        render_ack,
  output logic [31:0] render_data,
  input  logic        cpu_req,
  input  logic        cpu_wr,
  input  logic [22:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  output logic        cpu_ack,
  output logic [7:0]  cpu_rdata,
  input  logic        cmd_req,
  input  logic        cmd_wr,
  input  logic [1:0]  cmd_size,
  input  logic [22:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        cmd_ack,
  output logic [31:0] cmd_rdata,
  output logic        protocol_err,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_refresh,
  output logic [22:0] mem_addr,
  output logic [1:0]  mem_word_size,
  output logic [7:0]  mem_din8,
  output logic [31:0] mem_din32,
  input  logic [15:0] mem_dout16,
  input  logic [31:0] mem_dout32,
  input  logic        mem_busy,
  input  logic        mem_enabled
);

  if (FREQ <= 0 || REFRESH_INTERVAL < 2) begin : g_param_check
    $error("vram_arbiter: FREQ must be positive and REFRESH_INTERVAL at least 2");
  end

  localparam int CNT_W = $clog2(REFRESH_INTERVAL);
  localparam logic [CNT_W-1:0] CNT_RELOAD = CNT_W'(REFRESH_INTERVAL - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    G_REF    = 2'd0,
    G_RENDER = 2'd1,
    G_CPU    = 2'd2,
    G_CMD    = 2'd3
  } gnt_t;

  state_t            state_q, state_d;
  gnt_t              gnt_q, gnt_d;
  logic              rr_q, rr_d;
  logic [1:0]        pending_q, pending_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              mem_read_q, mem_read_d;
  logic              mem_write_q, mem_write_d;
  logic              mem_refresh_q, mem_refresh_d;
  logic [22:0]       mem_addr_q, mem_addr_d;
  logic [1:0]        mem_size_q, mem_size_d;
  logic [7:0]        mem_din8_q, mem_din8_d;
  logic [31:0]       mem_din32_q, mem_din32_d;
  logic              render_ack_q, render_ack_d;
  logic [31:0]       render_data_q, render_data_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic [7:0]        cpu_rdata_q, cpu_rdata_d;
  logic              cmd_ack_q, cmd_ack_d;
  logic [31:0]       cmd_rdata_q, cmd_rdata_d;
  logic              perr_q, perr_d;

  logic              ref_grant;
  logic              expire;
  logic              render_v, cpu_v, cmd_v;
  logic              cmd_illegal;
  logic [7:0]        rd_byte;

  // A port that was just acked is ignored for one IDLE cycle so a held req is not re-granted.
  assign render_v    = render_req & ~render_ack_q;
  assign cpu_v       = cpu_req & ~cpu_ack_q;
  assign cmd_v       = cmd_req & ~cmd_ack_q;
  assign cmd_illegal = (cmd_size == 2'b11) | (cmd_wr & (cmd_size == 2'b01));
  assign rd_byte     = mem_addr_q[0] ? mem_dout16[15:8] : mem_dout16[7:0];
  assign expire      = (cnt_q == {CNT_W{1'b0}});

  // Main sequencer: arbitration in IDLE, strobe in ISSUE, completion in WAIT.
  always_comb begin
    state_d       = state_q;
    gnt_d         = gnt_q;
    rr_d          = rr_q;
    mem_read_d    = 1'b0;
    mem_write_d   = 1'b0;
    mem_refresh_d = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_size_d    = mem_size_q;
    mem_din8_d    = mem_din8_q;
    mem_din32_d   = mem_din32_q;
    render_ack_d  = 1'b0;
    render_data_d = render_data_q;
    cpu_ack_d     = 1'b0;
    cpu_rdata_d   = cpu_rdata_q;
    cmd_ack_d     = 1'b0;
    cmd_rdata_d   = cmd_rdata_q;
    perr_d        = perr_q;
    ref_grant     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (mem_enabled && !mem_busy) begin
          if (pending_q >= 2'd2 || (!render_v && pending_q == 2'd1)) begin
            state_d       = S_ISSUE;
            gnt_d         = G_REF;
            mem_refresh_d = 1'b1;
            ref_grant     = 1'b1;
          end else if (render_v) begin
            state_d    = S_ISSUE;
            gnt_d      = G_RENDER;
            mem_read_d = 1'b1;
            mem_addr_d = render_addr;
            mem_size_d = 2'b10;
          end else if (cpu_v && (!cmd_v || !rr_q)) begin
            state_d     = S_ISSUE;
            gnt_d       = G_CPU;
            rr_d        = 1'b1;
            mem_read_d  = ~cpu_wr;
            mem_write_d = cpu_wr;
            mem_addr_d  = cpu_addr;
            mem_size_d  = 2'b00;
            mem_din8_d  = cpu_wdata;
            mem_din32_d = {24'd0, cpu_wdata};
          end else if (cmd_v) begin
            rr_d = 1'b0;
            // Unsupported command: answer immediately without touching memory.
            if (cmd_illegal) begin
              cmd_ack_d   = 1'b1;
              cmd_rdata_d = 32'd0;
              perr_d      = 1'b1;
            end else begin
              state_d     = S_ISSUE;
              gnt_d       = G_CMD;
              mem_read_d  = ~cmd_wr;
              mem_write_d = cmd_wr;
              mem_addr_d  = cmd_addr;
              mem_size_d  = cmd_size;
              mem_din8_d  = cmd_wdata[7:0];
              mem_din32_d = cmd_wdata;
            end
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      S_ISSUE: begin
        state_d = S_WAIT;
      end

      S_WAIT: begin
        if (!mem_busy) begin
          state_d = S_IDLE;
          case (gnt_q)
            G_RENDER: begin
              render_ack_d  = 1'b1;
              render_data_d = mem_dout32;
            end
            G_CPU: begin
              cpu_ack_d   = 1'b1;
              cpu_rdata_d = rd_byte;
            end
            G_CMD: begin
              cmd_ack_d = 1'b1;
              case (mem_size_q)
                2'b00:   cmd_rdata_d = {24'd0, rd_byte};
                2'b01:   cmd_rdata_d = {16'd0, mem_dout16};
                default: cmd_rdata_d = mem_dout32;
              endcase
            end
            default: begin
              render_ack_d = 1'b0;
            end
          endcase
        end else begin
          state_d = S_WAIT;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Refresh interval counter and saturating count of owed refreshes.
  always_comb begin
    cnt_d     = expire ? CNT_RELOAD : (cnt_q - CNT_ONE);
    pending_d = pending_q;
    case ({expire, ref_grant})
      2'b10: begin
        if (pending_q != 2'd3) begin
          pending_d = pending_q + 2'd1;
        end else begin
          pending_d = pending_q;
        end
      end
      2'b01:   pending_d = pending_q - 2'd1;
      default: pending_d = pending_q;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_IDLE;
      gnt_q         <= G_REF;
      rr_q          <= 1'b0;
      pending_q     <= 2'd0;
      cnt_q         <= CNT_RELOAD;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
      mem_refresh_q <= 1'b0;
      mem_addr_q    <= 23'd0;
      mem_size_q    <= 2'd0;
      mem_din8_q    <= 8'd0;
      mem_din32_q   <= 32'd0;
      render_ack_q  <= 1'b0;
      render_data_q <= 32'd0;
      cpu_ack_q     <= 1'b0;
      cpu_rdata_q   <= 8'd0;
      cmd_ack_q     <= 1'b0;
      cmd_rdata_q   <= 32'd0;
      perr_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      gnt_q         <= gnt_d;
      rr_q          <= rr_d;
      pending_q     <= pending_d;
      cnt_q         <= cnt_d;
      mem_read_q    <= mem_read_d;
      mem_write_q   <= mem_write_d;
      mem_refresh_q <= mem_refresh_d;
      mem_addr_q    <= mem_addr_d;
      mem_size_q    <= mem_size_d;
      mem_din8_q    <= mem_din8_d;
      mem_din32_q   <= mem_din32_d;
      render_ack_q  <= render_ack_d;
      render_data_q <= render_data_d;
      cpu_ack_q     <= cpu_ack_d;
      cpu_rdata_q   <= cpu_rdata_d;
      cmd_ack_q     <= cmd_ack_d;
      cmd_rdata_q   <= cmd_rdata_d;
      perr_q        <= perr_d;
    end
  end

  assign render_ack    = render_ack_q;
  assign render_data   = render_data_q;
  assign cpu_ack       = cpu_ack_q;
  assign cpu_rdata     = cpu_rdata_q;
  assign cmd_ack       = cmd_ack_q;
  assign cmd_rdata     = cmd_rdata_q;
  assign protocol_err  = perr_q;
  assign mem_read      = mem_read_q;
  assign mem_write     = mem_write_q;
  assign mem_refresh   = mem_refresh_q;
  assign mem_addr      = mem_addr_q;
  assign mem_word_size = mem_size_q;
  assign mem_din8      = mem_din8_q;
  assign mem_din32     = mem_din32_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed bench for vram_arbiter: main instance at the default refresh interval,
// second instance with a 20-cycle interval for refresh scheduling.
module tb_vram_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        reset;
  logic        render_req, render_ack;
  logic [22:0] render_addr;
  logic [31:0] render_data;
  logic        cpu_req, cpu_wr, cpu_ack;
  logic [22:0] cpu_addr;
  logic [7:0]  cpu_wdata, cpu_rdata;
  logic        cmd_req, cmd_wr, cmd_ack;
  logic [1:0]  cmd_size;
  logic [22:0] cmd_addr;
  logic [31:0] cmd_wdata, cmd_rdata;
  logic        protocol_err;
  logic        mem_read, mem_write, mem_refresh;
  logic [22:0] mem_addr;
  logic [1:0]  mem_word_size;
  logic [7:0]  mem_din8;
  logic [31:0] mem_din32;
  logic [15:0] mem_dout16;
  logic [31:0] mem_dout32;
  logic        mem_busy, mem_enabled;
  logic [2:0]  busy_cnt;
  logic        any_out;

  vram_arbiter u_dut (
    .clk(clk), .reset(reset),
    .render_req(render_req), .render_addr(render_addr), .render_ack(render_ack), .render_data(render_data),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .cmd_req(cmd_req), .cmd_wr(cmd_wr), .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .cmd_ack(cmd_ack), .cmd_rdata(cmd_rdata), .protocol_err(protocol_err),
    .mem_read(mem_read), .mem_write(mem_write), .mem_refresh(mem_refresh), .mem_addr(mem_addr),
    .mem_word_size(mem_word_size), .mem_din8(mem_din8), .mem_din32(mem_din32),
    .mem_dout16(mem_dout16), .mem_dout32(mem_dout32), .mem_busy(mem_busy), .mem_enabled(mem_enabled)
  );

  // Controller model: busy for 4 cycles starting the cycle after a strobe.
  always @(posedge clk) begin
    if (reset) busy_cnt <= 3'd0;
    else if (mem_read | mem_write | mem_refresh) busy_cnt <= 3'd4;
    else if (busy_cnt != 3'd0) busy_cnt <= busy_cnt - 3'd1;
  end
  assign mem_busy = (busy_cnt != 3'd0);
  assign any_out = |{render_ack, render_data, cpu_ack, cpu_rdata, cmd_ack, cmd_rdata, protocol_err,
                     mem_read, mem_write, mem_refresh, mem_addr, mem_word_size, mem_din8, mem_din32};

  logic        rf_reset, rf_render_req, rf_render_ack, rf_cpu_ack, rf_cmd_ack, rf_perr;
  logic [31:0] rf_render_data, rf_cmd_rdata, rf_din32;
  logic [7:0]  rf_cpu_rdata, rf_din8;
  logic        rf_read, rf_write, rf_refresh, rf_busy, rf_enabled;
  logic [22:0] rf_addr;
  logic [1:0]  rf_size;
  logic [2:0]  rf_busy_cnt;
  logic        rf_zero1;
  logic [1:0]  rf_zero2;
  logic [7:0]  rf_zero8;
  logic [15:0] rf_zero16;
  logic [22:0] rf_zero23;
  logic [31:0] rf_zero32;

  vram_arbiter #(.REFRESH_INTERVAL(20)) u_rf (
    .clk(clk), .reset(rf_reset),
    .render_req(rf_render_req), .render_addr(rf_zero23), .render_ack(rf_render_ack), .render_data(rf_render_data),
    .cpu_req(rf_zero1), .cpu_wr(rf_zero1), .cpu_addr(rf_zero23), .cpu_wdata(rf_zero8),
    .cpu_ack(rf_cpu_ack), .cpu_rdata(rf_cpu_rdata),
    .cmd_req(rf_zero1), .cmd_wr(rf_zero1), .cmd_size(rf_zero2), .cmd_addr(rf_zero23), .cmd_wdata(rf_zero32),
    .cmd_ack(rf_cmd_ack), .cmd_rdata(rf_cmd_rdata), .protocol_err(rf_perr),
    .mem_read(rf_read), .mem_write(rf_write), .mem_refresh(rf_refresh), .mem_addr(rf_addr),
    .mem_word_size(rf_size), .mem_din8(rf_din8), .mem_din32(rf_din32),
    .mem_dout16(rf_zero16), .mem_dout32(rf_zero32), .mem_busy(rf_busy), .mem_enabled(rf_enabled)
  );

  // Controller model for the refresh instance.
  always @(posedge clk) begin
    if (rf_reset) rf_busy_cnt <= 3'd0;
    else if (rf_read | rf_write | rf_refresh) rf_busy_cnt <= 3'd4;
    else if (rf_busy_cnt != 3'd0) rf_busy_cnt <= rf_busy_cnt - 3'd1;
  end
  assign rf_busy = (rf_busy_cnt != 3'd0);

  int checks = 0;
  int failures = 0;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_strobe(input string tag, input int max, output int at);
    at = -1;
    for (int i = 0; i < max && at < 0; i++) begin
      @(negedge clk);
      if (mem_read | mem_write | mem_refresh) at = cyc;
    end
    check_eq(tag, 64'(at >= 0), 64'd1);
  endtask

  task automatic wait_ack(input string tag, input int port, input int max, output int at);
    at = -1;
    for (int i = 0; i < max && at < 0; i++) begin
      @(negedge clk);
      if ((port == 0 && render_ack) || (port == 1 && cpu_ack) || (port == 2 && cmd_ack)) at = cyc;
    end
    check_eq(tag, 64'(at >= 0), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s, a, r, e, c, n, k, ovl, nref, idx, t0, expn;
    int seq [4];
    int kind [3];

    reset = 1'b1; rf_reset = 1'b1;
    render_req = 1'b0; render_addr = 23'd0;
    cmd_req = 1'b0; cmd_wr = 1'b0; cmd_size = 2'b00; cmd_addr = 23'd0; cmd_wdata = 32'd0;
    mem_dout16 = 16'd0; mem_dout32 = 32'd0; mem_enabled = 1'b0;
    rf_render_req = 1'b0; rf_enabled = 1'b0;
    rf_zero1 = 1'b0; rf_zero2 = 2'd0; rf_zero8 = 8'd0; rf_zero16 = 16'd0; rf_zero23 = 23'd0; rf_zero32 = 32'd0;
    cpu_req = 1'b1; cpu_wr = 1'b1; cpu_addr = 23'h000003; cpu_wdata = 8'hA5;
    seq = '{0, 0, 0, 0};
    kind = '{0, 0, 0};

    repeat (3) @(negedge clk);
    check_eq("reset_outputs", 64'(any_out), 64'd0);
    reset = 1'b0;

    // CPU write held across a 100-cycle controller start-up.
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n += int'(mem_read | mem_write | mem_refresh);
    end
    check_eq("no_strobe_disabled", 64'(n), 64'd0);
    e = cyc;
    mem_enabled = 1'b1;
    wait_strobe("t1_strobe_seen", 10, s);
    check_eq("t1_grant_lat", 64'(s - e), 64'd1);
    check_eq("t1_mem_write", 64'({mem_write, mem_read}), 64'b10);
    check_eq("t1_size", 64'(mem_word_size), 64'd0);
    check_eq("t1_din8", 64'(mem_din8), 64'hA5);
    check_eq("t1_addr", 64'(mem_addr), 64'h000003);
    wait_ack("t1_ack_seen", 1, 20, a);
    check_eq("t1_ack_after_strobe", 64'(a - s), 64'd6);
    cpu_req = 1'b0;

    // Render read.
    @(negedge clk);
    r = cyc;
    render_req = 1'b1; render_addr = 23'h000100; mem_dout32 = 32'hDEADBEEF;
    wait_strobe("t2_strobe_seen", 10, s);
    check_eq("t2_read_size", 64'({mem_read, mem_word_size}), 64'b110);
    check_eq("t2_addr", 64'(mem_addr), 64'h000100);
    wait_ack("t2_ack_seen", 0, 20, a);
    check_eq("t2_ack_lat", 64'(a - r), 64'd7);
    check_eq("t2_data", 64'(render_data), 64'hDEADBEEF);
    render_req = 1'b0;
    mem_dout32 = 32'h0BADF00D;
    repeat (3) @(negedge clk);
    check_eq("t2_data_held", 64'(render_data), 64'hDEADBEEF);

    // Command reads of 16 and 8 bits, then an illegal 16-bit write.
    @(negedge clk);
    cmd_req = 1'b1; cmd_wr = 1'b0; cmd_size = 2'b01; cmd_addr = 23'h000006; mem_dout16 = 16'h1234;
    wait_strobe("t5_strobe_seen", 10, s);
    check_eq("t5_read_size", 64'({mem_read, mem_word_size}), 64'b101);
    check_eq("t5_addr", 64'(mem_addr), 64'h000006);
    wait_ack("t5_ack_seen", 2, 20, a);
    check_eq("t5_rdata16", 64'(cmd_rdata), 64'h00001234);
    cmd_req = 1'b0;
    @(negedge clk);
    cmd_req = 1'b1; cmd_size = 2'b00; cmd_addr = 23'h000007;
    wait_ack("t5b_ack_seen", 2, 20, a);
    check_eq("t5_rdata8_hi", 64'(cmd_rdata), 64'h00000012);
    cmd_req = 1'b0;
    @(negedge clk);
    c = cyc;
    cmd_req = 1'b1; cmd_wr = 1'b1; cmd_size = 2'b01; cmd_addr = 23'h000008; cmd_wdata = 32'h000055AA;
    n = 0; a = -1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n += int'(mem_read | mem_write | mem_refresh);
      if (cmd_ack && a < 0) begin
        a = cyc;
        cmd_req = 1'b0;
        check_eq("t5_illegal_rdata", 64'(cmd_rdata), 64'd0);
      end
    end
    check_eq("t5_illegal_ack_lat", 64'(a - c), 64'd1);
    check_eq("t5_illegal_no_strobe", 64'(n), 64'd0);
    check_eq("t5_protocol_err", 64'(protocol_err), 64'd1);
    cmd_wr = 1'b0; cmd_req = 1'b0;

    // Reset in the middle of a CPU read.
    @(negedge clk);
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 23'h000005;
    wait_strobe("t6_strobe_seen", 10, s);
    repeat (2) @(negedge clk);
    reset = 1'b1; cpu_req = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check_eq("t6_reset_outputs", 64'(any_out), 64'd0);
    check_eq("t6_pending", 64'(u_dut.pending_q), 64'd0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n += int'(cpu_ack | render_ack | cmd_ack);
    end
    check_eq("t6_no_ack", 64'(n), 64'd0);
    r = cyc;
    render_req = 1'b1; render_addr = 23'h000200; mem_dout32 = 32'h01020304;
    wait_ack("t6_ack_seen", 0, 20, a);
    check_eq("t6_ack_lat", 64'(a - r), 64'd7);
    check_eq("t6_data", 64'(render_data), 64'h01020304);
    render_req = 1'b0;

    // CPU and command both requesting continuously.
    @(negedge clk);
    cpu_req = 1'b1; cpu_wr = 1'b0; cpu_addr = 23'h000011;
    cmd_req = 1'b1; cmd_wr = 1'b0; cmd_size = 2'b10; cmd_addr = 23'h000040;
    mem_dout16 = 16'h1234; mem_dout32 = 32'hCAFEF00D;
    k = 0; ovl = 0;
    for (int i = 0; i < 80 && k < 4; i++) begin
      @(negedge clk);
      if (cpu_ack && cmd_ack) begin
        ovl++;
      end else if (cpu_ack) begin
        seq[k] = 1; k++;
        check_eq("t3_cpu_rdata", 64'(cpu_rdata), 64'h12);
      end else if (cmd_ack) begin
        seq[k] = 2; k++;
        check_eq("t3_cmd_rdata", 64'(cmd_rdata), 64'hCAFEF00D);
      end
    end
    cpu_req = 1'b0; cmd_req = 1'b0;
    check_eq("t3_ack_count", 64'(k), 64'd4);
    check_eq("t3_no_overlap", 64'(ovl), 64'd0);
    check_eq("t3_order", 64'({seq[0][3:0], seq[1][3:0], seq[2][3:0], seq[3][3:0]}), 64'h1212);

    // Refresh scheduling with continuous render traffic, 20-cycle interval.
    @(negedge clk);
    rf_render_req = 1'b1; rf_enabled = 1'b0; rf_reset = 1'b0;
    t0 = cyc;
    repeat (45) @(negedge clk);
    rf_enabled = 1'b1;
    nref = 0; idx = 0;
    while (cyc - t0 < 400) begin
      @(negedge clk);
      if (rf_refresh) nref++;
      if ((rf_read | rf_refresh) && idx < 3) begin
        kind[idx] = int'(rf_refresh);
        idx++;
      end
    end
    expn = (cyc - t0) / 20;
    check_eq("rf_urgent_first", 64'(kind[0]), 64'd1);
    check_eq("rf_render_beats_pend1", 64'(kind[1]), 64'd0);
    check_eq("rf_slip_after_render", 64'(kind[2]), 64'd1);
    check_eq("rf_count_in_range", 64'(nref >= expn - 1 && nref <= expn + 1), 64'd1);
    if (nref < expn - 1 || nref > expn + 1)
      $display("refresh strobes %0d over %0d cycles", nref, cyc - t0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
